// File: rtl/dcache_controller_pkg.sv
// rtl/dcache_controller_pkg.sv - shared constants, types and line helpers for the L1 data cache
package dcache_controller_pkg;

    localparam int LINES     = 16;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;

    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS    = LINE_BITS / 32;
    localparam int WORD_W   = $clog2(WORDS);

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [INDEX_W-1:0]   index_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_e;

    // Pick one 32-bit word out of a cache line.
    function automatic logic [31:0] line_word(input line_t line, input word_t w);
        return line[w*32 +: 32];
    endfunction

    // Replace one 32-bit word inside a cache line.
    function automatic line_t merge_word(input line_t line, input word_t w, input logic [31:0] data);
        line_t r;
        r = line;
        r[w*32 +: 32] = data;
        return r;
    endfunction

    // Line-aligned byte address for a tag/index pair.
    function automatic logic [ADDR_W-1:0] line_base(input tag_t tag, input index_t index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU and memory side signals of the data cache
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic                 cpu_req_i;
    logic                 cpu_write_i;
    logic [ADDR_W-1:0]    cpu_addr_i;
    logic [31:0]          cpu_data_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_stall_o;

    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - LINES x {valid, dirty, tag, data} storage, async read / sync write
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  index_t rd_index_i,
    output logic   rd_valid_o,
    output logic   rd_dirty_o,
    output tag_t   rd_tag_o,
    output line_t  rd_line_o,
    input  logic   wr_en_i,
    input  index_t wr_index_i,
    input  logic   wr_dirty_i,
    input  tag_t   wr_tag_i,
    input  line_t  wr_line_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    tag_t             tag_q  [LINES];
    line_t            data_q [LINES];

    // Status bits: cleared asynchronously so a reset invalidates the whole cache at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
            dirty_q[wr_index_i] <= wr_dirty_i;
        end
    end

    // Tag and data payload: no reset needed, guarded by the valid bit.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_controller_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    line_t             mem_data_q, mem_data_d;

    tag_t   cpu_tag;
    index_t cpu_index;
    word_t  cpu_word;
    tag_t   miss_tag_d;
    index_t miss_index_d;

    logic   rd_valid, rd_dirty;
    tag_t   rd_tag;
    line_t  rd_line;
    logic   wr_en, wr_dirty;
    index_t wr_index;
    tag_t   wr_tag;
    line_t  wr_line;
    logic   hit;
    logic   unused_addr_bits;

    assign cpu_tag      = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_index    = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_word     = bus.cpu_addr_i[2 +: WORD_W];
    assign miss_tag_d   = miss_addr_d[ADDR_W-1 -: TAG_W];
    assign miss_index_d = miss_addr_d[OFFSET_W +: INDEX_W];
    assign hit          = rd_valid && (rd_tag == cpu_tag);

    // Byte-within-word bits and the latched offset are deliberately ignored.
    assign unused_addr_bits = ^{bus.cpu_addr_i[1:0], miss_addr_q[OFFSET_W-1:0]};

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index_i (cpu_index),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (wr_en),
        .wr_index_i (wr_index),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (wr_tag),
        .wr_line_i  (wr_line)
    );

    // State register; reset mid-miss abandons the transfer immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Next-state logic; a dirty victim goes out before the new line comes in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req_i && !hit) begin
                    state_d = rd_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: if (bus.mem_ack_i) state_d = ST_ALLOCATE;
            ST_ALLOCATE:  if (bus.mem_ack_i) state_d = ST_REFILL;
            ST_REFILL:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // CPU-facing outputs and array writes: store-hit merge in IDLE, line fill on the allocate ack.
    always_comb begin
        bus.cpu_stall_o = !rst_i && ((state_q != ST_IDLE) || (bus.cpu_req_i && !hit));
        bus.cpu_data_o  = rst_i ? 32'd0 : line_word(rd_line, cpu_word);

        wr_en    = 1'b0;
        wr_index = cpu_index;
        wr_tag   = cpu_tag;
        wr_dirty = 1'b1;
        wr_line  = merge_word(rd_line, cpu_word, bus.cpu_data_i);

        if (state_q == ST_IDLE && bus.cpu_req_i && bus.cpu_write_i && hit) begin
            wr_en = 1'b1;
        end else if (state_q == ST_ALLOCATE && bus.mem_ack_i) begin
            wr_en    = 1'b1;
            wr_index = miss_addr_q[OFFSET_W +: INDEX_W];
            wr_tag   = miss_addr_q[ADDR_W-1 -: TAG_W];
            wr_dirty = 1'b0;
            wr_line  = bus.mem_data_i;
        end
    end

    // Memory request next-values; address/data are captured once per request and held until ack.
    always_comb begin
        miss_addr_d  = (state_q == ST_IDLE && state_d != ST_IDLE) ? bus.cpu_addr_i : miss_addr_q;
        mem_enable_d = (state_d == ST_WRITEBACK) || (state_d == ST_ALLOCATE);
        mem_write_d  = (state_d == ST_WRITEBACK);
        mem_addr_d   = '0;
        mem_data_d   = mem_data_q;
        if (state_d == ST_WRITEBACK) begin
            if (state_q == ST_IDLE) begin
                mem_addr_d = line_base(rd_tag, cpu_index);
                mem_data_d = rd_line;
            end else begin
                mem_addr_d = mem_addr_q;
            end
        end else if (state_d == ST_ALLOCATE) begin
            mem_addr_d = line_base(miss_tag_d, miss_index_d);
        end
    end

    // Registered memory interface so the request is glitch-free for the whole transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for the L1 data cache controller
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    localparam int ACK_LAT = 10;
    localparam int BOUND   = 300;

    logic clk = 1'b0;
    logic rst;
    logic model_ack;
    logic spur_ack;

    always #5 clk = ~clk;

    dcache_controller_if bus();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.mem_ack_i = model_ack | spur_ack;

    int checks = 0;
    int errors = 0;
    int fetch_cnt = 0;
    int wb_cnt = 0;

    logic [31:0] load_q[$];
    logic [63:0] wb_q[$];
    line_t       mem_store[logic [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic line_t pat_line(input logic [31:0] base);
        line_t l;
        for (int w = 0; w < WORDS; w++) begin
            l[w*32 +: 32] = 32'hC0DE_0000 | ((base + 32'(w * 4)) & 32'h0000_FFFF);
        end
        return l;
    endfunction

    // Memory: counts ACK_LAT enabled cycles then pulses ack; one idle cycle after each ack.
    initial begin
        int cnt;
        cnt = 0;
        model_ack = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_ack = 1'b0;
                cnt = 0;
            end else if (model_ack) begin
                model_ack = 1'b0;
                cnt = 0;
            end else if (bus.mem_enable_o) begin
                cnt++;
                if (cnt == ACK_LAT) begin
                    model_ack = 1'b1;
                    if (bus.mem_write_o) begin
                        mem_store[bus.mem_addr_o] = bus.mem_data_o;
                        wb_cnt++;
                    end else begin
                        bus.mem_data_i = mem_store.exists(bus.mem_addr_o) ?
                                         mem_store[bus.mem_addr_o] : pat_line(bus.mem_addr_o);
                        fetch_cnt++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected load data and write-back records as the DUT presents them.
    initial begin
        logic [31:0] e;
        logic [63:0] w;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.cpu_req_i && !bus.cpu_write_i && !bus.cpu_stall_o) begin
                    if (load_q.size() == 0) begin
                        check("unexpected_load", {32'd0, bus.cpu_addr_i}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = load_q.pop_front();
                        check("load_data", {32'd0, bus.cpu_data_o}, {32'd0, e});
                    end
                end
                if (bus.mem_enable_o && bus.mem_write_o && bus.mem_ack_i) begin
                    if (wb_q.size() == 0) begin
                        check("unexpected_wb", {32'd0, bus.mem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_addr", {32'd0, bus.mem_addr_o}, {32'd0, w[63:32]});
                        check("wb_word0", {32'd0, bus.mem_data_o[31:0]}, {32'd0, w[31:0]});
                    end
                end
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stall, input string name);
        int n;
        @(negedge clk);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_write_i = wr;
        bus.cpu_addr_i  = addr;
        bus.cpu_data_i  = wdata;
        if (!wr) load_q.push_back(exp_rdata);
        n = 0;
        #1;
        while (bus.cpu_stall_o && n < BOUND) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        bus.cpu_req_i   = 1'b0;
        bus.cpu_write_i = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, w0, n;
        rst = 1'b1;
        spur_ack = 1'b0;
        bus.cpu_req_i = 1'b0;
        bus.cpu_write_i = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        #2;
        check("rst_stall",  {63'd0, bus.cpu_stall_o},  64'd0);
        check("rst_enable", {63'd0, bus.mem_enable_o}, 64'd0);
        check("rst_write",  {63'd0, bus.mem_write_o},  64'd0);
        check("rst_addr",   {32'd0, bus.mem_addr_o},   64'd0);
        check("rst_data",   {32'd0, bus.cpu_data_o},   64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: cold load, single allocate, L+2 stall
        f0 = fetch_cnt; w0 = wb_cnt;
        access(1'b0, 32'h40, 32'h0, 32'hC0DE_0040, 12, "t1_cold");
        check("t1_fetches", 64'(fetch_cnt - f0), 64'd1);
        check("t1_wbs",     64'(wb_cnt - w0),    64'd0);

        // 2: neighbouring word hits with no memory traffic
        f0 = fetch_cnt;
        access(1'b0, 32'h44, 32'h0, 32'hC0DE_0044, 0, "t2_hit");
        check("t2_enable",  {63'd0, bus.mem_enable_o}, 64'd0);
        check("t2_fetches", 64'(fetch_cnt - f0), 64'd0);

        // 3: store hit dirties the line, conflicting load evicts it
        access(1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, "t3_store");
        wb_q.push_back({32'h40, 32'hDEAD_BEEF});
        f0 = fetch_cnt; w0 = wb_cnt;
        access(1'b0, 32'h240, 32'h0, 32'hC0DE_0240, 23, "t3_evict");
        check("t3_fetches", 64'(fetch_cnt - f0), 64'd1);
        check("t3_wbs",     64'(wb_cnt - w0),    64'd1);
        access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 12, "t3_reload");

        // 4: store miss to a clean line allocates then merges
        f0 = fetch_cnt; w0 = wb_cnt;
        access(1'b1, 32'h300, 32'h1234_5678, 32'h0, 12, "t4_store_miss");
        check("t4_fetches", 64'(fetch_cnt - f0), 64'd1);
        check("t4_wbs",     64'(wb_cnt - w0),    64'd0);
        idle(2);
        access(1'b0, 32'h304, 32'h0, 32'hC0DE_0304, 0, "t4_other_word");
        access(1'b0, 32'h300, 32'h0, 32'h1234_5678, 0, "t4_reload");
        wb_q.push_back({32'h300, 32'h1234_5678});
        access(1'b0, 32'h100, 32'h0, 32'hC0DE_0100, 23, "t4_evict");

        // 5: reset during allocate
        @(negedge clk);
        bus.cpu_req_i = 1'b1;
        bus.cpu_write_i = 1'b0;
        bus.cpu_addr_i = 32'h80;
        repeat (5) @(negedge clk);
        #1;
        check("t5_pre_enable", {63'd0, bus.mem_enable_o}, 64'd1);
        check("t5_pre_write",  {63'd0, bus.mem_write_o},  64'd0);
        check("t5_pre_addr",   {32'd0, bus.mem_addr_o},   64'h80);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_enable", {63'd0, bus.mem_enable_o}, 64'd0);
        check("t5_rst_stall",  {63'd0, bus.cpu_stall_o},  64'd0);
        check("t5_rst_addr",   {32'd0, bus.mem_addr_o},   64'd0);
        check("t5_rst_data",   {32'd0, bus.cpu_data_o},   64'd0);
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h80, 32'h0, 32'hC0DE_0080, 12, "t5_miss_after_rst");

        // 6: spurious ack in idle is ignored
        idle(1);
        f0 = fetch_cnt;
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        #1;
        check("t6_spur_enable", {63'd0, bus.mem_enable_o}, 64'd0);
        check("t6_spur_stall",  {63'd0, bus.cpu_stall_o},  64'd0);
        access(1'b0, 32'h84, 32'h0, 32'hC0DE_0084, 0, "t6_spur_hit");
        check("t6_fetches", 64'(fetch_cnt - f0), 64'd0);

        // 6b: request dropped mid-miss, fill still completes
        @(negedge clk);
        bus.cpu_req_i = 1'b1;
        bus.cpu_write_i = 1'b0;
        bus.cpu_addr_i = 32'h400;
        repeat (3) @(negedge clk);
        bus.cpu_req_i = 1'b0;
        n = 0;
        #1;
        while (bus.cpu_stall_o && n < BOUND) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("t6_drop_done", 64'(n < BOUND), 64'd1);
        access(1'b0, 32'h404, 32'h0, 32'hC0DE_0404, 0, "t6_drop_hit");
        idle(2);

        check("load_q_drained", 64'(load_q.size()), 64'd0);
        check("wb_q_drained",   64'(wb_q.size()),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
